// File: rtl/shift_pipe_pkg.sv
// Shared types for the pipelined barrel shifter: shift modes, default widths
// and the per-stage payload layout at the default width.
package shift_pipe_pkg;

    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned SHW_DEF = $clog2(DW_DEF);

    typedef logic [DW_DEF-1:0] data_t;

    typedef enum logic [1:0] {
        ModeSll = 2'd0,
        ModeSrl = 2'd1,
        ModeSra = 2'd2,
        ModeRol = 2'd3
    } shift_mode_e;

    typedef struct packed {
        data_t              data;
        logic [SHW_DEF-1:0] shamt;
        shift_mode_e        mode;
        logic               sign;
        logic               valid;
    } stage_payload_t;

endpackage

// File: rtl/shift_pipe_stage.sv
// One barrel-shifter stage: conditionally shifts by 2^K and registers the
// payload, holding everything while the pipe is stalled.
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int unsigned K   = 0,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned SHW = $clog2(DW)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           advance_i,
    input  logic           valid_i,
    input  logic [DW-1:0]  data_i,
    input  logic [SHW-1:0] shamt_i,
    input  shift_mode_e    mode_i,
    input  logic           sign_i,
    output logic           valid_o,
    output logic [DW-1:0]  data_o,
    output logic [SHW-1:0] shamt_o,
    output shift_mode_e    mode_o,
    output logic           sign_o
);

    localparam int unsigned Dist = 1 << K;

    logic [DW-1:0]  shifted;
    logic [DW-1:0]  data_d, data_q;
    logic [SHW-1:0] shamt_q;
    shift_mode_e    mode_q;
    logic           sign_q, valid_q;

    always_comb begin
        shifted = data_i;
        unique case (mode_i)
            ModeSll: shifted = data_i << Dist;
            ModeSrl: shifted = data_i >> Dist;
            // Fill comes from the original operand's sign, not the current top bit.
            ModeSra: shifted = (data_i >> Dist) | (sign_i ? ~({DW{1'b1}} >> Dist) : '0);
            ModeRol: shifted = (data_i << Dist) | (data_i >> (DW - Dist));
            default: shifted = data_i;
        endcase
        data_d = shamt_i[K] ? shifted : data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= ModeSll;
            sign_q  <= 1'b0;
        end else if (advance_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            shamt_q <= shamt_i;
            mode_q  <= mode_i;
            sign_q  <= sign_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) resolving one shift-amount bit per
// stage, with valid/ready on both sides and a single global stall.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    localparam int unsigned SHW = $clog2(DW)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [DW-1:0]  i_val,
    input  logic [SHW-1:0] i_shamt,
    input  logic [1:0]     i_mode,
    input  logic           i_enable,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [DW-1:0]  o_val,
    output logic           o_busy
);

    logic           advance;
    logic [SHW:0]   vld;
    logic [SHW:0]   sgn;
    logic [DW-1:0]  dat  [SHW+1];
    logic [SHW-1:0] sha  [SHW+1];
    shift_mode_e    mode [SHW+1];
    logic           unused_tail;

    assign advance = ~o_valid | i_ready;
    assign o_ready = advance;

    // A disabled operand enters as zero, so every mode keeps it zero.
    assign vld[0]  = i_valid & advance;
    assign dat[0]  = i_enable ? i_val : '0;
    assign sgn[0]  = i_enable & i_val[DW-1];
    assign sha[0]  = i_shamt;
    assign mode[0] = shift_mode_e'(i_mode);

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_pipe_stage #(
            .K   (k),
            .DW  (DW),
            .SHW (SHW)
        ) u_stage (
            .clk_i     (clk),
            .rst_i     (rst),
            .advance_i (advance),
            .valid_i   (vld[k]),
            .data_i    (dat[k]),
            .shamt_i   (sha[k]),
            .mode_i    (mode[k]),
            .sign_i    (sgn[k]),
            .valid_o   (vld[k+1]),
            .data_o    (dat[k+1]),
            .shamt_o   (sha[k+1]),
            .mode_o    (mode[k+1]),
            .sign_o    (sgn[k+1])
        );
    end

    assign o_valid = vld[SHW];
    assign o_val   = dat[SHW];
    assign o_busy  = |vld[SHW:1];

    assign unused_tail = ^{sha[SHW], sgn[SHW], mode[SHW]};

endmodule
